// File: rtl/idu_pkg.sv
// rtl/idu_pkg.sv - opcode constants, control encodings and decoded bundle type for the decode stage
package idu_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [6:0]  FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    EXT_I = 3'd0,
    EXT_S = 3'd1,
    EXT_B = 3'd2,
    EXT_U = 3'd3,
    EXT_J = 3'd4
  } ext_type_e;

  typedef enum logic [1:0] {
    RW_NONE = 2'd0,
    RW_ALU  = 2'd1,
    RW_MEM  = 2'd2,
    RW_PC4  = 2'd3
  } reg_write_e;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2,
    PC_JALR   = 2'd3
  } pc_src_e;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_ctrl_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    ext_type_e  ext_type;
    logic       alu_src;
    reg_write_e reg_write;
    pc_src_e    pc_src;
    alu_ctrl_e  alu_ctrl;
    logic       mem_read;
    logic       mem_write;
    logic       rs2_valid;
    logic       word;
    logic       ebreak;
    logic       illegal;
  } idu_bundle_t;

  // alt selects SUB over ADD and SRA over SRL
  function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_ctrl_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/idu_decode.sv
// rtl/idu_decode.sv - combinational RV32I/RV64I decoder producing the EXU control bundle
module idu_decode
  import idu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]  inst,
  output idu_bundle_t  bundle
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [5:0] funct6;
  logic       f7_zero;
  logic       f7_alt;
  logic       ok;
  idu_bundle_t d;

  assign opcode  = inst[6:0];
  assign funct3  = inst[14:12];
  assign funct7  = inst[31:25];
  assign funct6  = inst[31:26];
  assign f7_zero = (funct7 == 7'd0);
  assign f7_alt  = (funct7 == FUNCT7_ALT);

  always_comb begin
    d     = '0;
    d.rd  = inst[11:7];
    d.rs1 = inst[19:15];
    d.rs2 = inst[24:20];
    ok    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ok = 1'b1; d.ext_type = EXT_U; d.reg_write = RW_ALU; d.alu_ctrl = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        ok = 1'b1; d.ext_type = EXT_U; d.alu_src = 1'b1; d.reg_write = RW_ALU;
      end
      OPC_JAL: begin
        ok = 1'b1; d.ext_type = EXT_J; d.alu_src = 1'b1; d.reg_write = RW_PC4; d.pc_src = PC_JAL;
      end
      OPC_JALR: begin
        ok = (funct3 == 3'b000); d.reg_write = RW_PC4; d.pc_src = PC_JALR;
      end
      OPC_BRANCH: begin
        ok = !(funct3 inside {3'b010, 3'b011});
        d.ext_type = EXT_B; d.alu_src = 1'b1; d.pc_src = PC_BRANCH; d.rs2_valid = 1'b1;
      end
      OPC_LOAD: begin
        ok = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
             || (RV64 && (funct3 inside {3'b011, 3'b110}));
        d.reg_write = RW_MEM; d.mem_read = 1'b1;
      end
      OPC_STORE: begin
        ok = (funct3 inside {3'b000, 3'b001, 3'b010}) || (RV64 && funct3 == 3'b011);
        d.ext_type = EXT_S; d.mem_write = 1'b1; d.rs2_valid = 1'b1;
      end
      OPC_OP_IMM: begin
        d.reg_write = RW_ALU;
        d.alu_ctrl  = alu_from_funct3(funct3, (funct3 == 3'b101) && inst[30]);
        // RV32 shamt is 5 bits, so inst[25] must stay clear; RV64 takes it as shamt[5]
        case (funct3)
          3'b001:  ok = RV64 ? (funct6 == 6'd0) : f7_zero;
          3'b101:  ok = RV64 ? (funct6 == 6'd0 || funct6 == FUNCT7_ALT[6:1]) : (f7_zero || f7_alt);
          default: ok = 1'b1;
        endcase
      end
      OPC_OP: begin
        ok = f7_zero || (f7_alt && (funct3 inside {3'b000, 3'b101}));
        d.reg_write = RW_ALU; d.rs2_valid = 1'b1;
        d.alu_ctrl  = alu_from_funct3(funct3, funct7[5]);
      end
      OPC_OP_IMM32: begin
        if (RV64) begin
          ok = (funct3 == 3'b000) || (funct3 == 3'b001 && f7_zero)
               || (funct3 == 3'b101 && (f7_zero || f7_alt));
          d.reg_write = RW_ALU; d.word = 1'b1;
          d.alu_ctrl  = alu_from_funct3(funct3, (funct3 == 3'b101) && inst[30]);
        end
      end
      OPC_OP32: begin
        if (RV64) begin
          ok = ((funct3 inside {3'b000, 3'b101}) && (f7_zero || f7_alt))
               || (funct3 == 3'b001 && f7_zero);
          d.reg_write = RW_ALU; d.word = 1'b1; d.rs2_valid = 1'b1;
          d.alu_ctrl  = alu_from_funct3(funct3, funct7[5]);
        end
      end
      OPC_SYSTEM: begin
        ok       = (inst == INST_EBREAK);
        d.ebreak = ok;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d         = '0;
      d.rd      = inst[11:7];
      d.rs1     = inst[19:15];
      d.rs2     = inst[24:20];
      d.illegal = 1'b1;
    end
  end

  assign bundle = d;

endmodule

// File: rtl/idu_pipe.sv
// rtl/idu_pipe.sv - registered decode stage with skid buffer and RUN/HALT trap state
module idu_pipe
  import idu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_ext_type,
  output logic            out_alu_src,
  output logic [1:0]      out_reg_write,
  output logic [1:0]      out_pc_src,
  output logic [3:0]      out_alu_ctrl,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_rs2_valid,
  output logic            out_word,
  output logic            out_ebreak,
  output logic            out_illegal,
  output logic            halted
);

  idu_bundle_t     dec;
  idu_bundle_t     main_q;
  idu_bundle_t     skid_q;
  logic [PC_W-1:0] main_pc;
  logic [PC_W-1:0] skid_pc;
  logic            main_valid;
  logic            skid_valid;
  logic            take;
  logic            consume;
  logic            trap;
  state_e          state;
  state_e          state_next;

  idu_decode #(.XLEN(XLEN)) u_decode (
    .inst   (in_inst),
    .bundle (dec)
  );

  assign in_ready = (state == ST_RUN) && !skid_valid;
  // an instruction offered during flush is dropped, so it neither enters nor traps
  assign take     = in_valid && in_ready && !flush;
  assign consume  = main_valid && out_ready;
  assign trap     = take && (dec.ebreak || dec.illegal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:  if (trap) state_next = ST_HALT;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_RUN;
    endcase
  end

  // skid is only ever filled while main is held, so skid_valid implies main_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      main_pc    <= '0;
      skid_q     <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || consume) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_pc    <= skid_pc;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (take) begin
        main_q     <= dec;
        main_pc    <= in_pc;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (take) begin
      skid_q     <= dec;
      skid_pc    <= in_pc;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid     = main_valid;
  assign out_pc        = main_pc;
  assign out_rd        = main_q.rd;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_ext_type  = main_q.ext_type;
  assign out_alu_src   = main_q.alu_src;
  assign out_reg_write = main_q.reg_write;
  assign out_pc_src    = main_q.pc_src;
  assign out_alu_ctrl  = main_q.alu_ctrl;
  assign out_mem_read  = main_q.mem_read;
  assign out_mem_write = main_q.mem_write;
  assign out_rs2_valid = main_q.rs2_valid;
  assign out_word      = main_q.word;
  assign out_ebreak    = main_q.ebreak;
  assign out_illegal   = main_q.illegal;
  assign halted        = (state == ST_HALT);

endmodule

// File: tb/tb_idu_pipe.sv
// tb/tb_idu_pipe.sv - self-checking bench for idu_pipe (XLEN=32 and XLEN=64 instances)
module tb_idu_pipe;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] ext;
    logic       alu_src;
    logic [1:0] rw;
    logic [1:0] pcs;
    logic [3:0] alu;
    logic       mr;
    logic       mw;
    logic       r2v;
    logic       word;
    logic       ebreak;
    logic       illegal;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } item_t;

  localparam logic [31:0] ADDI   = 32'h0050_0093;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] SLLI32 = 32'h0200_9093;
  localparam logic [7:0]  BR_OK   = 8'b1111_0011;
  localparam logic [7:0]  LD32_OK = 8'b0011_0111;
  localparam logic [7:0]  LD64_OK = 8'b0111_1111;
  localparam logic [7:0]  ST32_OK = 8'b0000_0111;
  localparam logic [7:0]  ST64_OK = 8'b0000_1111;
  localparam logic [3:0]  ALU_BY_F3 [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

  logic clk = 1'b0;
  logic rst, in_valid, flush, out_ready;
  logic [31:0] in_inst, in_pc;

  logic a_in_ready, a_out_valid, a_alu_src, a_mem_read, a_mem_write, a_rs2_valid, a_word, a_ebreak, a_illegal, a_halted;
  logic [31:0] a_out_pc;
  logic [4:0] a_rd, a_rs1, a_rs2;
  logic [2:0] a_ext_type;
  logic [1:0] a_reg_write, a_pc_src;
  logic [3:0] a_alu_ctrl;
  logic b_in_ready, b_out_valid, b_alu_src, b_mem_read, b_mem_write, b_rs2_valid, b_word, b_ebreak, b_illegal, b_halted;
  logic [31:0] b_out_pc;
  logic [4:0] b_rd, b_rs1, b_rs2;
  logic [2:0] b_ext_type;
  logic [1:0] b_reg_write, b_pc_src;
  logic [3:0] b_alu_ctrl;

  exp_t obs_a, obs_b;
  assign obs_a = {a_rd, a_rs1, a_rs2, a_ext_type, a_alu_src, a_reg_write, a_pc_src, a_alu_ctrl,
                  a_mem_read, a_mem_write, a_rs2_valid, a_word, a_ebreak, a_illegal};
  assign obs_b = {b_rd, b_rs1, b_rs2, b_ext_type, b_alu_src, b_reg_write, b_pc_src, b_alu_ctrl,
                  b_mem_read, b_mem_write, b_rs2_valid, b_word, b_ebreak, b_illegal};

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  idu_pipe #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
    .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_ext_type(a_ext_type), .out_alu_src(a_alu_src),
    .out_reg_write(a_reg_write), .out_pc_src(a_pc_src), .out_alu_ctrl(a_alu_ctrl),
    .out_mem_read(a_mem_read), .out_mem_write(a_mem_write), .out_rs2_valid(a_rs2_valid),
    .out_word(a_word), .out_ebreak(a_ebreak), .out_illegal(a_illegal), .halted(a_halted)
  );

  idu_pipe #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_ext_type(b_ext_type), .out_alu_src(b_alu_src),
    .out_reg_write(b_reg_write), .out_pc_src(b_pc_src), .out_alu_ctrl(b_alu_ctrl),
    .out_mem_read(b_mem_read), .out_mem_write(b_mem_write), .out_rs2_valid(b_rs2_valid),
    .out_word(b_word), .out_ebreak(b_ebreak), .out_illegal(b_illegal), .halted(b_halted)
  );

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference decoder: opcode table plus funct3 legality bitmaps
  function automatic exp_t model(input logic [31:0] i, input bit rv64);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] a;
    logic alt, ok;
    f3 = i[14:12];
    f7 = i[31:25];
    alt = (f7 == 7'h20);
    a = ALU_BY_F3[f3];
    e = '0;
    e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
    ok = 1'b0;
    case (i[6:0])
      7'h37: begin ok = 1'b1; e.ext = 3'd3; e.rw = 2'd1; e.alu = 4'd10; end
      7'h17: begin ok = 1'b1; e.ext = 3'd3; e.alu_src = 1'b1; e.rw = 2'd1; end
      7'h6f: begin ok = 1'b1; e.ext = 3'd4; e.alu_src = 1'b1; e.rw = 2'd3; e.pcs = 2'd2; end
      7'h67: begin ok = (f3 == 3'd0); e.rw = 2'd3; e.pcs = 2'd3; end
      7'h63: begin ok = BR_OK[f3]; e.ext = 3'd2; e.alu_src = 1'b1; e.pcs = 2'd1; e.r2v = 1'b1; end
      7'h03: begin ok = rv64 ? LD64_OK[f3] : LD32_OK[f3]; e.rw = 2'd2; e.mr = 1'b1; end
      7'h23: begin ok = rv64 ? ST64_OK[f3] : ST32_OK[f3]; e.ext = 3'd1; e.mw = 1'b1; e.r2v = 1'b1; end
      7'h13: begin
        e.rw = 2'd1; e.alu = a;
        if (f3 == 3'd1) ok = rv64 ? (i[31:26] == 6'd0) : (f7 == 7'd0);
        else if (f3 == 3'd5) begin
          ok = rv64 ? (i[31:26] == 6'd0 || i[31:26] == 6'h10) : (f7 == 7'd0 || alt);
          e.alu = a + 4'(i[30]);
        end else ok = 1'b1;
      end
      7'h33: begin
        e.rw = 2'd1; e.r2v = 1'b1; e.alu = a + 4'(alt);
        ok = (f7 == 7'd0) || (alt && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h1b: if (rv64) begin
        e.rw = 2'd1; e.word = 1'b1; e.alu = a + 4'(f3 == 3'd5 && alt);
        ok = (f3 == 3'd0) || (f3 == 3'd1 && f7 == 7'd0) || (f3 == 3'd5 && (f7 == 7'd0 || alt));
      end
      7'h3b: if (rv64) begin
        e.rw = 2'd1; e.r2v = 1'b1; e.word = 1'b1; e.alu = a + 4'(alt);
        ok = ((f3 == 3'd0 || f3 == 3'd5) && (f7 == 7'd0 || alt)) || (f3 == 3'd1 && f7 == 7'd0);
      end
      7'h73: begin ok = (i == EBREAK); e.ebreak = ok; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.ext = '0; e.alu_src = 1'b0; e.rw = '0; e.pcs = '0; e.alu = '0;
      e.mr = 1'b0; e.mw = 1'b0; e.r2v = 1'b0; e.word = 1'b0; e.ebreak = 1'b0; e.illegal = 1'b1;
    end
    return e;
  endfunction

  // only write/mem/pc_src and register fields are defined for illegal bundles
  function automatic exp_t mask(input exp_t x);
    exp_t m;
    m = x;
    if (m.illegal) begin
      m.ext = '0; m.alu_src = 1'b0; m.alu = '0; m.r2v = 1'b0; m.word = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [14];
    logic [31:0] w;
    int k;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1b, 7'h3b, 7'h73, 7'h0f, 7'h7f};
    w = $urandom;
    k = $urandom_range(0, 13);
    if (k < 13) w[6:0] = ops[k];
    if (w[6:0] == 7'h73 && w[7]) w = EBREAK;
    else if (w[6:0] inside {7'h13, 7'h33, 7'h1b, 7'h3b} && w[8]) begin
      w[31:26] = {1'b0, w[9], 4'd0};
      if (w[10]) w[14:12] = {w[11], 2'b01};
    end
    return w;
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [6:0] ops [9];
    logic [31:0] w;
    exp_t e;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    for (int t = 0; t < 200; t++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 8)];
      w[31:25] = w[30] ? 7'h20 : 7'h00;
      e = model(w, 1'b0);
      if (!e.illegal && !e.ebreak) return w;
    end
    return ADDI;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // mode 0: always ready (addi stream), 1: out_ready low for 3 cycles, 2: random handshakes
  task automatic run_stream(input int n, input int mode, input string tag);
    item_t q[$];
    item_t pend;
    int sent, got, cyc;
    logic acc, cons;
    sent = 0; got = 0; cyc = 0;
    pend.inst = (mode == 0) ? ADDI : rand_legal();
    pend.pc = $urandom & 32'hffff_fffc;
    chk({tag, "_idle"}, a_out_valid, 1'b0);
    while ((sent < n || q.size() > 0) && cyc < 20 * n + 50) begin
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = (cyc >= 3);
      else out_ready = $urandom_range(0, 1);
      in_valid = (sent < n) && (mode != 2 || $urandom_range(0, 3) != 0);
      in_inst = pend.inst;
      in_pc = pend.pc;
      chk({tag, "_in_ready"}, a_in_ready, q.size() < 2);
      acc = in_valid && (q.size() < 2);
      cons = (q.size() > 0) && out_ready;
      step();
      cyc++;
      if (cons) begin
        void'(q.pop_front());
        got++;
      end
      if (acc) begin
        q.push_back(pend);
        sent++;
        pend.inst = (mode == 0) ? ADDI : rand_legal();
        pend.pc = pend.pc + 32'd4;
      end
      chk({tag, "_out_valid"}, a_out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk({tag, "_bundle"}, mask(obs_a), mask(model(q[0].inst, 1'b0)));
        chk({tag, "_pc"}, a_out_pc, q[0].pc);
      end
    end
    in_valid = 1'b0;
    chk({tag, "_delivered"}, got, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t addi_exp, e32, e64;
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_halted", a_halted, 1'b0);
    chk("rst_fields", obs_a, '0);
    chk("rst_pc", a_out_pc, '0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", a_in_ready, 1'b1);

    addi_exp = '{rd: 5'd1, rs1: 5'd0, rs2: 5'd5, ext: 3'd0, alu_src: 1'b0, rw: 2'd1, pcs: 2'd0, alu: 4'd0,
                 mr: 1'b0, mw: 1'b0, r2v: 1'b0, word: 1'b0, ebreak: 1'b0, illegal: 1'b0};
    in_inst = ADDI; in_pc = 32'h8000_0000; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("addi_valid", a_out_valid, 1'b1);
    chk("addi_bundle", obs_a, addi_exp);
    chk("addi_pc", a_out_pc, 32'h8000_0000);
    step();
    chk("addi_drained", a_out_valid, 1'b0);

    run_stream(8, 0, "tput");
    run_stream(4, 1, "bp");
    run_stream(60, 2, "rand");

    out_ready = 1'b1; in_inst = EBREAK; in_pc = 32'h100; in_valid = 1'b1;
    step();
    chk("ebreak_flag", a_ebreak, 1'b1);
    chk("ebreak_halted", a_halted, 1'b1);
    chk("ebreak_in_ready", a_in_ready, 1'b0);
    in_inst = ADDI;
    step();
    chk("halt_no_accept", a_out_valid, 1'b0);
    step();
    chk("halt_stays", a_halted, 1'b1);
    chk("halt_no_accept2", a_out_valid, 1'b0);
    in_valid = 1'b0;
    pulse_rst();
    chk("rst_leaves_halt", a_halted, 1'b0);
    chk("rst_in_ready2", a_in_ready, 1'b1);

    step();
    in_inst = SLLI32; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("slli32_illegal", a_illegal, 1'b1);
    chk("slli32_halted", a_halted, 1'b1);
    chk("slli64_illegal", b_illegal, 1'b0);
    chk("slli64_alu", b_alu_ctrl, 4'd2);
    chk("slli64_halted", b_halted, 1'b0);
    pulse_rst();
    step();

    out_ready = 1'b0; in_inst = ADDI; in_valid = 1'b1;
    step();
    step();
    chk("flush_full", a_in_ready, 1'b0);
    in_inst = EBREAK; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", a_out_valid, 1'b0);
    chk("flush_halted", a_halted, 1'b0);
    chk("flush_in_ready", a_in_ready, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_valid", a_out_valid, 1'b0);
    chk("flush_drop_halted", a_halted, 1'b0);

    in_inst = EBREAK; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("arst_pre_valid", a_out_valid, 1'b1);
    chk("arst_pre_halted", a_halted, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", a_out_valid, 1'b0);
    chk("arst_halted", a_halted, 1'b0);
    rst = 1'b0;
    step();

    out_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      in_inst = rand_inst();
      in_pc = $urandom;
      in_valid = 1'b1;
      e32 = model(in_inst, 1'b0);
      e64 = model(in_inst, 1'b1);
      step();
      in_valid = 1'b0;
      chk("sweep_valid32", a_out_valid, 1'b1);
      chk("sweep_dec32", mask(obs_a), mask(e32));
      chk("sweep_dec64", mask(obs_b), mask(e64));
      chk("sweep_halt32", a_halted, e32.ebreak | e32.illegal);
      chk("sweep_halt64", b_halted, e64.ebreak | e64.illegal);
      chk("sweep_ready64", b_in_ready, !(e64.ebreak | e64.illegal));
      if (a_halted || b_halted) pulse_rst();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idu_pipe.md
# idu_pipe

Pipelined, parametrised instruction decode stage for the NPC core. It sits between IFU and EXU and decodes RV32I/RV64I base instructions into the EXU control bundle. Unlike the single-cycle decoder, it registers its output behind a valid/ready handshake with a one-entry skid buffer. It flags illegal encodings, including XLEN-dependent shift-amount checks, and replaces the DPI trap calls with a registered RUN/HALT state machine driven by ebreak or illegal instructions.

## Interface
- XLEN, 32: datapath width, 32 or 64; selects shamt legality and OP-IMM-32/OP-32 support.
- PC_W, 32: width of the PC carried alongside the instruction.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  IFU offers in_inst/in_pc.
- in_ready  out  1  stage accepts this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  PC_W  instruction address.
- flush  in  1  discard all held and incoming instructions.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EXU consumes bundle.
- out_pc  out  PC_W  PC of bundle.
- out_rd, out_rs1, out_rs2  out  5 each  register addresses, raw instruction fields.
- out_ext_type  out  3  immediate format: 0 I, 1 S, 2 B, 3 U, 4 J.
- out_alu_src  out  1  1 = operand A is PC (auipc, jal, branches).
- out_reg_write  out  2  0 none, 1 ALU, 2 load data, 3 PC+4.
- out_pc_src  out  2  0 PC+4, 1 branch, 2 jal, 3 jalr.
- out_alu_ctrl  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- out_mem_read, out_mem_write  out  1 each  load/store.
- out_rs2_valid  out  1  instruction reads rs2 (branch, store, OP, OP-32).
- out_word  out  1  32-bit op on RV64; always 0 when XLEN=32.
- out_ebreak, out_illegal  out  1 each  trap flags of the bundle.
- halted  out  1  state is HALT.

## Operation
- Decoding is combinational on in_inst. The result plus in_pc is captured in the main register on accept (in_valid && in_ready).
- Two entries: main (drives out_*) and skid. If main is occupied and not being consumed, the accepted bundle goes to skid. When main drains, skid moves to main.
- in_ready = (state == RUN) && !skid_valid. It is a registered-state function with no combinational path from out_ready.
- Illegal: unknown opcode; bad funct3/funct7 for the opcode; SYSTEM other than exact ebreak (0x00100073); inst[25]=1 on slli/srli/srai when XLEN=32; opcodes 0011011/0111011 when XLEN=32. Illegal bundles carry out_illegal=1, and all write/mem/pc_src fields are forced to 0.
- FSM RUN→HALT: taken on the cycle an ebreak or illegal instruction is accepted. HALT is left only by rst. In HALT, in_ready=0. Already-held bundles, including the trap bundle, still drain to EXU normally.
- flush: clears main and skid valid next edge. An instruction offered in the same cycle is dropped. An ebreak/illegal accepted in a flush cycle does not cause HALT. Flush does not leave HALT.
- Out-bundle fields hold stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0, skid empty, state RUN, halted=0, all out_* fields 0. in_ready=1 once reset is released.
- Latency is 1 cycle: accepted at edge N, out_valid high after edge N.
- Throughput is 1 instruction per cycle with out_ready held high.
- Backpressure: at most 2 instructions are held; in_ready falls the cycle after skid fills.
- Simultaneous accept and consume with skid empty: the new bundle replaces main and out_valid stays 1.
- Reset asserted mid-operation clears all entries and HALT asynchronously. In-flight bundles are lost.

## Structure
- Package idu_pkg holds the opcode constants and the ext_type, reg_write, pc_src and alu_ctrl encodings above, plus a packed struct for the decoded bundle.
- Sub-module idu_decode is purely combinational: in_inst → bundle plus illegal/ebreak, parametrised by XLEN.
- idu_pipe holds the skid buffer, handshake and FSM.

## Test plan
- Stream of addi x1,x0,5 (0x00500093) with out_ready=1 → out_valid one cycle later; rd=1, rs1=0, ext_type=0, alu_ctrl=ADD, reg_write=1; one bundle per cycle.
- 4 back-to-back instructions with out_ready=0 for 3 cycles → in_ready drops after 2 accepts; in-order delivery, none lost or duplicated.
- ebreak (0x00100073) followed by addi → ebreak bundle out_ebreak=1; halted=1 next cycle; addi never accepted; rst returns to RUN.
- slli x1,x1,32 (0x02009093) → with XLEN=32, out_illegal=1 and halted=1; with XLEN=64, legal, alu_ctrl=SLL.
- flush asserted while main and skid are full and ebreak is offered → out_valid=0 next cycle; halted stays 0.
- rst pulsed asynchronously between edges while out_valid=1 → out_valid and halted drop immediately.
